// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8-bit-in / 16-bit-out single-clock FIFO.
package fifo_pkg;
  localparam int WR_W     = 8;
  localparam int WR_DEPTH = 256;
  localparam int AW       = $clog2(WR_DEPTH);
  localparam int RATIO    = 2;
  localparam int RD_W     = RATIO * WR_W;

  typedef logic [RD_W-1:0] word_t;
endpackage

// File: rtl/fifo_ram_bytelane.sv
// Word-organised register array with a per-lane byte-enable write port and a
// registered read port whose output register clears on reset.
module fifo_ram_bytelane
  import fifo_pkg::*;
#(
  parameter int LANE_W = WR_W,
  parameter int LANES  = RATIO,
  parameter int DEPTH  = WR_DEPTH / RATIO,
  parameter int DAW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [DAW-1:0]            waddr,
  input  logic [LANES-1:0]          be,
  input  logic [LANES*LANE_W-1:0]   wdata,
  input  logic                      re,
  input  logic [DAW-1:0]            raddr,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  // Read register holds its value whenever no read is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mixed_width_fifo.sv
// Single-clock FIFO: byte-wide write side, halfword-wide read side, with
// independent fill levels and flags for each side.
module mixed_width_fifo #(
  parameter int WR_W     = fifo_pkg::WR_W,
  parameter int WR_DEPTH = fifo_pkg::WR_DEPTH,
  parameter int AW       = $clog2(WR_DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_req,
  input  logic [WR_W-1:0]   wr_data,
  input  logic              rd_req,
  output logic              wr_full,
  output logic              wr_empty,
  output logic [AW:0]       wr_usedw,
  output logic              rd_full,
  output logic              rd_empty,
  output logic [AW-1:0]     rd_usedw,
  output logic [2*WR_W-1:0] rd_data
);
  import fifo_pkg::*;

  // Handshake: a request is taken only when its own side's flag allows it
  // (wr_req & ~wr_full, rd_req & ~rd_empty); refused requests are dropped.
  logic [AW:0]   wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;
  logic [1:0]    be;

  // rp counts words, so it is scaled to bytes before the subtraction.
  assign wr_usedw = wp - {rp, 1'b0};
  assign rd_usedw = wr_usedw[AW:1];
  assign wr_full  = (wr_usedw == (AW+1)'(WR_DEPTH));
  assign wr_empty = (wr_usedw == '0);
  assign rd_full  = (rd_usedw == AW'(WR_DEPTH / 2));
  assign rd_empty = (rd_usedw == '0);

  assign wr_ok = wr_req & ~wr_full;
  assign rd_ok = rd_req & ~rd_empty;
  assign be    = wp[0] ? 2'b10 : 2'b01;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
    end
  end

  fifo_ram_bytelane #(
    .LANE_W (WR_W),
    .LANES  (RATIO),
    .DEPTH  (WR_DEPTH / 2),
    .DAW    (AW - 1)
  ) u_ram (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .we    (wr_ok),
    .waddr (wp[AW-1:1]),
    .be    (be),
    .wdata ({wr_data, wr_data}),
    .re    (rd_ok),
    .raddr (rp[AW-2:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mixed_width_fifo.sv
// Randomised bench for mixed_width_fifo against a byte-queue reference model.
module tb_mixed_width_fifo;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_req = 1'b0;
  logic        wr_full, wr_empty, rd_full, rd_empty;
  logic [8:0]  wr_usedw;
  logic [7:0]  rd_usedw;
  logic [15:0] rd_data;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_rd = 16'h0000;

  mixed_width_fifo dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .wr_full   (wr_full),
    .wr_empty  (wr_empty),
    .wr_usedw  (wr_usedw),
    .rd_full   (rd_full),
    .rd_empty  (rd_empty),
    .rd_usedw  (rd_usedw),
    .rd_data   (rd_data)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check_eq("wr_usedw", 32'(wr_usedw), 32'(sz));
    check_eq("rd_usedw", 32'(rd_usedw), 32'(sz / 2));
    check_eq("wr_full",  32'(wr_full),  32'(sz == 256));
    check_eq("wr_empty", 32'(wr_empty), 32'(sz == 0));
    check_eq("rd_full",  32'(rd_full),  32'(sz / 2 == 128));
    check_eq("rd_empty", 32'(rd_empty), 32'(sz < 2));
    check_eq("rd_data",  32'(rd_data),  32'(exp_rd));
  endtask

  // driver: one clock with the given requests, then model update and check
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic wr_ok, rd_ok;
    logic [7:0] lo, hi;
    @(negedge sys_clk);
    wr_req = w; wr_data = d; rd_req = r;
    @(posedge sys_clk);
    wr_ok = w && (exp_q.size() < 256);
    rd_ok = r && (exp_q.size() >= 2);
    if (rd_ok) begin
      lo = exp_q.pop_front();
      hi = exp_q.pop_front();
      exp_rd = {hi, lo};
    end
    if (wr_ok) exp_q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    @(negedge sys_clk);
    wr_req = 1'b0; rd_req = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rd = 16'h0000;
    check_all();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // power-on reset, released away from the clock edge
    repeat (3) @(posedge sys_clk);
    #1 check_all();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    #1 check_all();

    // single byte, ignored read, pair completion, read
    cycle(1'b1, 8'hA5, 1'b0);
    check_eq("one_byte_usedw", 32'(wr_usedw), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("ignored_read_data", 32'(rd_data), 32'h0);
    cycle(1'b1, 8'h3C, 1'b0);
    check_eq("pair_rd_usedw", 32'(rd_usedw), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("pair_read_data", 32'(rd_data), 32'h3CA5);
    cycle(1'b0, 8'h00, 1'b0);

    // reset in the middle of a fill
    for (int i = 0; i < 37; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    check_eq("midfill_usedw", 32'(wr_usedw), 32'd37);
    async_reset();
    check_eq("after_reset_usedw", 32'(wr_usedw), 32'd0);

    // slow fill 0..255, overfill attempt, continuous drain
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0);
    end
    check_eq("fill_wr_full", 32'(wr_full), 32'd1);
    check_eq("fill_rd_full", 32'(rd_full), 32'd1);
    cycle(1'b1, 8'hEE, 1'b0);
    check_eq("overfill_usedw", 32'(wr_usedw), 32'd256);
    for (int i = 0; i < 128; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check_eq("drain_seq", 32'(rd_data), 32'({8'(2*i+1), 8'(2*i)}));
    end
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("drained_wr_empty", 32'(wr_empty), 32'd1);
    check_eq("drained_hold", 32'(rd_data), 32'hFFFE);

    // repeated full fill/drain to wrap both pointers
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 128; i++) cycle(1'b0, 8'h00, 1'b1);
    end

    // simultaneous read and write with 10 bytes stored
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    check_eq("simul_wr_usedw", 32'(wr_usedw), 32'd9);
    check_eq("simul_rd_usedw", 32'(rd_usedw), 32'd4);
    cycle(1'b1, 8'h88, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    check_eq("simul_tail", 32'(rd_data), 32'h8877);

    // random traffic with shifting request densities
    for (int p = 0; p < 6; p++) begin
      int wpct, rpct;
      wpct = $urandom_range(10, 100);
      rpct = $urandom_range(10, 100);
      for (int i = 0; i < 500; i++)
        cycle(1'($urandom_range(1, 100) <= wpct), 8'($urandom_range(0, 255)),
              1'($urandom_range(1, 100) <= rpct));
    end
    async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
